// File: rtl/preamble_tx_pkg.sv
// Shared definitions for the preamble transmitter and detector.
// One-hot FSM encoding, default preamble and idle line level.
package preamble_tx_pkg;

  localparam int I_IDLE = 0;
  localparam int I_LOAD = 1;
  localparam int I_PRE  = 2;
  localparam int I_DATA = 3;

  typedef enum logic [3:0] {
    IDLE = 4'b0001 << I_IDLE,
    LOAD = 4'b0001 << I_LOAD,
    PRE  = 4'b0001 << I_PRE,
    DATA = 4'b0001 << I_DATA
  } state_t;

  localparam logic [7:0] PREAMBLE_DEF   = 8'hAA;
  localparam logic       IDLE_LEVEL_DEF = 1'b0;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/preamble_tx_piso_shift.sv
// Parallel-in serial-out shift register, MSB first.
// Load has priority over shift when both are asserted.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par_in,
  output logic         msb
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= par_in;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/preamble_tx.sv
// Serial frame transmitter: preamble then payload, MSB first,
// one line bit per bit_en strobe.
module preamble_tx
  import preamble_tx_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               PRE_W      = 8,
  parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(PREAMBLE_DEF),
  parameter logic             IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  localparam int CNT_W = $clog2(max2(PRE_W, DATA_W) + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic dout_q;
  logic dout_d;
  logic done_q;
  logic done_d;

  logic load;
  logic pre_sh;
  logic pay_sh;
  logic pre_msb;
  logic pay_msb;

  piso_shift #(
    .W (PRE_W)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (pre_sh),
    .par_in (PREAMBLE),
    .msb    (pre_msb)
  );

  piso_shift #(
    .W (DATA_W)
  ) u_pay (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (pay_sh),
    .par_in (data_in),
    .msb    (pay_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dout_q <= IDLE_LEVEL;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end

  // The acceptance edge only loads; bit_en is not looked at there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pre_sh  = 1'b0;
    pay_sh  = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      state_q[I_LOAD]: begin
        if (bit_en) begin
          state_d = PRE;
          dout_d  = pre_msb;
          pre_sh  = 1'b1;
        end
      end
      state_q[I_PRE]: begin
        if (bit_en) begin
          if (cnt_q == PRE_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
            dout_d  = pay_msb;
            pay_sh  = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            dout_d = pre_msb;
            pre_sh = 1'b1;
          end
        end
      end
      state_q[I_DATA]: begin
        if (bit_en) begin
          if (cnt_q == DAT_LAST) begin
            state_d = IDLE;
            dout_d  = IDLE_LEVEL;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            dout_d = pay_msb;
            pay_sh = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        dout_d  = IDLE_LEVEL;
      end
    endcase
  end

  assign ready = state_q[I_IDLE];
  assign busy  = ~state_q[I_IDLE];
  assign done  = done_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_preamble_tx.sv
// Directed and random frames against a bit-queue model
// of the transmitter line.
module tb_preamble_tx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       start;
  logic [7:0] data_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       dout;

  preamble_tx dut (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (bit_en),
    .start   (start),
    .data_in (data_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: an accepted frame becomes a queue of line bits;
  // each bit_en pops one, an empty queue ends the frame.
  bit       m_active;
  bit       m_dout;
  bit       m_done;
  bit       m_q[$];
  logic [7:0] pre_v = 8'hAA;

  int mode = 0;
  int pace = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_dout   = 1'b0;
    m_done   = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_q.delete();
        for (int i = 7; i >= 0; i--) m_q.push_back(pre_v[i]);
        for (int i = 7; i >= 0; i--) m_q.push_back(data_in[i]);
      end
    end else if (bit_en) begin
      if (m_q.size() > 0) begin
        m_dout = m_q.pop_front();
      end else begin
        m_dout   = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic step();
    case (mode)
      0:       bit_en = 1'b1;
      1:       bit_en = (pace % 4 == 0);
      default: bit_en = 1'($urandom_range(1));
    endcase
    pace++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dout",  dout,  m_dout);
    chk("busy",  busy,  m_active);
    chk("ready", ready, !m_active);
    chk("done",  done,  m_done);
  endtask

  // Steps from cycle 2 after acceptance until done (bit_en=1).
  task automatic capture(
    input  int          pulse_k,
    output logic [15:0] bits,
    output int          done_k
  );
    bits   = '0;
    done_k = -1;
    for (int k = 2; k <= 60; k++) begin
      if (pulse_k > 0) begin
        start = (k == pulse_k);
        if (k == pulse_k) data_in = 8'hFF;
      end
      step();
      if (k <= 17) bits = {bits[14:0], dout};
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  logic [15:0] bits;
  logic [16:0] line;
  int          dk;
  int          n;

  initial begin
    rst     = 1'b0;
    bit_en  = 1'b0;
    start   = 1'b0;
    data_in = 8'h00;
    model_reset();

    // 1: reset and idle
    repeat (3) step();
    rst = 1'b1;
    repeat (4) step();

    // 2: single frame C3
    start   = 1'b1;
    data_in = 8'hC3;
    step();
    start = 1'b0;
    capture(0, bits, dk);
    chk("t2_bits", bits, 16'hAAC3);
    chk("t2_done_cycle", dk, 18);
    line = {bits, 1'b0};
    n = 0;
    for (int i = 0; i <= 9; i++) begin
      if (line[16-i -: 8] == 8'hAA) n++;
    end
    chk("t2_det_flags", n, 1);
    repeat (3) step();

    // 3: paced line, bit_en every 4th cycle
    mode    = 1;
    start   = 1'b1;
    data_in = 8'h0F;
    step();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (done) n++;
    end
    chk("t3_done_pulses", n, 1);
    mode = 0;

    // 4: back-to-back with start held high
    start   = 1'b1;
    data_in = 8'h55;
    step();
    data_in = 8'hAA;
    capture(0, bits, dk);
    chk("t4_bits_a", bits, 16'hAA55);
    chk("t4_done_a", dk, 18);
    chk("t4_ready_done", ready, 1);
    step();
    start = 1'b0;
    chk("t4_busy_b", busy, 1);
    capture(0, bits, dk);
    chk("t4_bits_b", bits, 16'hAAAA);
    chk("t4_done_b", dk, 18);

    // 5: start while busy is ignored
    start   = 1'b1;
    data_in = 8'h00;
    step();
    start = 1'b0;
    capture(8, bits, dk);
    start   = 1'b0;
    data_in = 8'h00;
    chk("t5_bits", bits, 16'hAA00);
    chk("t5_done", dk, 18);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (busy) n++;
    end
    chk("t5_no_extra", n, 0);

    // 6: abort during payload bit 3
    start   = 1'b1;
    data_in = 8'h5A;
    step();
    start = 1'b0;
    for (int k = 2; k <= 14; k++) step();
    chk("t6_bit3", dout, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_abort_dout",  dout,  0);
    chk("t6_abort_busy",  busy,  0);
    chk("t6_abort_ready", ready, 1);
    chk("t6_abort_done",  done,  0);
    repeat (3) step();
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) n++;
    end
    chk("t6_no_done", n, 0);
    start   = 1'b1;
    data_in = 8'h81;
    step();
    start = 1'b0;
    capture(0, bits, dk);
    chk("t6_bits", bits, 16'hAA81);
    chk("t6_done", dk, 18);

    // Random traffic, random bit_en
    mode = 2;
    for (int k = 0; k < 600; k++) begin
      start   = ($urandom_range(3) == 0);
      data_in = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
